// File: rtl/prescaled_timer_pkg.sv
// Shared types and constants for the prescaled seconds/event timer.
package prescaled_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DN       = 1'b1;
    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (longint unsigned p = 1; p < longint'(v); p = p << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/prescaled_timer_prescaler.sv
// Reusable strobe generator: divides clk by CLK_HZ/TICK_HZ while enabled.
module tick_prescaler
    import prescaled_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic hold_clr,
    output logic tick
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] r_cnt;

    // Combinational strobe on the terminal edge; the owner registers it.
    assign tick = en && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (hold_clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/prescaled_timer.sv
// Seconds/event timer: prescaled tick drives an up/down WIDTH-bit counter with run control.
module prescaled_timer
    import prescaled_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned WIDTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             dir,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap,
    output logic             done,
    output logic             running
);

    state_t           r_state;
    state_t           w_state_n;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_n;
    logic             r_tick;
    logic             w_tick_n;
    logic             r_wrap;
    logic             w_wrap_n;
    logic             w_pre_en;
    logic             w_pre_clr;
    logic             w_ptick;
    logic             w_term;

    // Control inputs freeze the prescaler so stop/load/clear always beat a tick.
    assign w_pre_en  = (r_state == ST_RUN) && !clear && !load && !stop;
    assign w_pre_clr = clear || load || ((r_state == ST_DONE) && start);

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (w_pre_en),
        .hold_clr (w_pre_clr),
        .tick     (w_ptick)
    );

    assign w_term = (dir == DIR_DN) ? (r_count == '0) : (r_count >= limit);

    always_comb begin
        w_state_n = r_state;
        w_count_n = r_count;
        w_tick_n  = 1'b0;
        w_wrap_n  = 1'b0;
        if (clear) begin
            w_state_n = ST_IDLE;
            w_count_n = '0;
        end else if (load) begin
            w_count_n = (load_val > limit) ? limit : load_val;
            if (r_state == ST_DONE) begin
                w_state_n = ST_IDLE;
            end
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) w_state_n = ST_RUN;
                end
                ST_RUN: begin
                    if (stop) begin
                        w_state_n = ST_PAUSE;
                    end else if (w_ptick) begin
                        w_tick_n = 1'b1;
                        if (!w_term) begin
                            w_count_n = (dir == DIR_DN) ? r_count - WIDTH'(1) : r_count + WIDTH'(1);
                        end else if (mode == MODE_WRAP) begin
                            w_count_n = (dir == DIR_DN) ? limit : '0;
                            w_wrap_n  = 1'b1;
                        end else begin
                            w_count_n = (dir == DIR_DN) ? '0 : limit;
                            w_state_n = ST_DONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start) w_state_n = ST_RUN;
                end
                ST_DONE: begin
                    if (start) begin
                        w_state_n = ST_RUN;
                        w_count_n = (dir == DIR_DN) ? limit : '0;
                    end
                end
                default: w_state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_count <= w_count_n;
            r_tick  <= w_tick_n;
            r_wrap  <= w_wrap_n;
        end
    end

    assign count   = r_count;
    assign tick    = r_tick;
    assign wrap    = r_wrap;
    assign done    = (r_state == ST_DONE);
    assign running = (r_state == ST_RUN);

endmodule
